hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and flow-control unit for the 5-stage RV32I core. It is the driver side of the pipeline-register control interface: it generates the per-stage load enables and active-low flushes that IF/ID and ID/EX consume, and the forwarding selects for EX. It also freezes the whole pipeline while the LSU is busy, with a watchdog on freeze length, and keeps stall and flush event counters.

## Interface
- `TIMEOUT`, default 255: maximum consecutive LSU-busy cycles before `o_mem_timeout` is set.
- `CNT_W`, default 32: width of the event counters.
- `i_clk` in 1: core clock.
- `i_reset` in 1: asynchronous, active-low reset.
- `rs1_addr_id`, `rs2_addr_id` in 5 each: source registers of the instruction in ID.
- `rs1_addr_ex`, `rs2_addr_ex` in 5 each: source registers of the instruction in EX.
- `rd_addr_ex`, `rd_wren_ex`, `wb_sel_ex` in 5/1/2: destination, write enable and writeback select in EX. Load is `WB_MEM = 2'b01`.
- `rd_addr_mem`, `rd_wren_mem` in 5/1: MEM-stage destination and write enable.
- `rd_addr_wb`, `rd_wren_wb` in 5/1: WB-stage destination and write enable.
- `pc_sel_ex` in 1: taken branch or jump resolved in EX (redirect).
- `i_lsu_busy` in 1: LSU cannot complete its access this cycle.
- `o_pc_en` out 1: PC load enable.
- `o_enable_if` out 1: IF/ID load enable.
- `o_enable_id` out 1: ID/EX load enable.
- `o_flush_if_n` out 1: active-low synchronous clear into IF/ID; the register loads a NOP.
- `o_flush_id_n` out 1: active-low synchronous clear into ID/EX; the register loads NOP `0x0000_0013`.
- `o_fwd_a_sel`, `o_fwd_b_sel` out 2 each: EX operand source. `00` = register file, `01` = MEM result, `10` = WB data.
- `o_mem_timeout` out 1: sticky watchdog flag.
- `o_stall_cnt`, `o_flush_cnt` out CNT_W each: event counters.

## Operation
- **Condition priority:** freeze > redirect > load-use > run.
- **Freeze** (`i_lsu_busy=1`):
  - `o_pc_en`, `o_enable_if` and `o_enable_id` are all 0.
  - Both flush outputs are 1; no bubbles are inserted.
  - A redirect present during freeze stays pending, because EX is frozen. It is acted on in the first non-busy cycle.
- **Redirect** (`pc_sel_ex=1`, not frozen):
  - `o_flush_if_n=0` and `o_flush_id_n=0`.
  - All enables are 1, so the PC takes the target.
  - Any load-use condition in the same cycle is ignored, because the ID instruction is wrong-path.
- **Load-use**:
  - Condition: `rd_wren_ex`, `wb_sel_ex==WB_MEM`, `rd_addr_ex!=0`, and `rd_addr_ex` equals `rs1_addr_id` or `rs2_addr_id`.
  - Response: `o_pc_en=0`, `o_enable_if=0`, `o_flush_id_n=0` (bubble), `o_enable_id=1`.
  - The condition clears itself the next cycle, since the bubble has no write enable.
- **Run:** all enables are 1 and both flush outputs are 1.
- **Forwarding** (per operand, combinational, independent of freeze):
  - MEM match selects `01`: `rd_wren_mem`, `rd_addr_mem!=0`, `rd_addr_mem==rsX_addr_ex`.
  - Otherwise WB match selects `10`, under the same conditions on the WB stage.
  - Otherwise `00`. MEM wins when both stages match.
- **FSM** (`RUN`, `MEM_WAIT`):
  - `RUN` goes to `MEM_WAIT` when `i_lsu_busy=1`.
  - `MEM_WAIT` returns to `RUN` when `i_lsu_busy=0`.
  - Wait counter: cleared in `RUN`, increments every cycle in `MEM_WAIT` and saturates at `TIMEOUT`.
  - `o_mem_timeout` is set on the edge where the counter reaches `TIMEOUT` while `i_lsu_busy=1`. It stays set until reset.
- **Counters** (wrap modulo 2^CNT_W):
  - `o_stall_cnt` increments on each clock edge where freeze or load-use was active.
  - `o_flush_cnt` increments on each edge where a redirect was acted on. Pending redirects during freeze do not count.

## Timing
- Enable, flush and forward outputs are combinational from inputs and state, valid in the same cycle.
- FSM state, wait counter, `o_mem_timeout` and event counters update on the rising edge of `i_clk`.
- **While `i_reset=0`:**
  - Asynchronously forced: `o_pc_en=0`, `o_enable_if=0`, `o_enable_id=0`, `o_flush_if_n=0`, `o_flush_id_n=0`, `o_fwd_*_sel=00`, `o_mem_timeout=0`.
  - Counters, wait counter and state are held at 0 / `RUN`.
  - Downstream pipeline registers therefore load NOPs during reset.
- **First cycle after reset release:** normal evaluation, with no extra stall.
- **Reset mid-freeze:** state returns to `RUN` immediately and the watchdog clears.
- **Freeze of exactly `TIMEOUT` cycles:** flag set. `TIMEOUT-1` cycles: flag stays 0.

## Structure
- Package `pipe_pkg` holds:
  - `WB_MEM`, `WB_ALU`, `WB_PC4`
  - forwarding select constants `FWD_RF`, `FWD_MEM`, `FWD_WB`
  - the `hz_state_e` enum
- One natural sub-module: `fwd_sel`, the per-operand forwarding comparator, instantiated twice.
- Priority logic and FSM live in `hazard_ctrl`.

## Test plan
- **Load-use stall:**
  - Stimulus: load x5 in EX; ID reads rs1=x5.
  - Required: one cycle of `o_pc_en=0`, `o_enable_if=0`, `o_flush_id_n=0`, then run. `o_stall_cnt` 0 -> 1.
- **Redirect over load-use:**
  - Stimulus: `pc_sel_ex=1` in the same cycle as a load-use match.
  - Required: both flush outputs 0, all enables 1, `o_flush_cnt=1`, `o_stall_cnt` unchanged.
- **Freeze with pending redirect:**
  - Stimulus: `i_lsu_busy=1` for 3 cycles with `pc_sel_ex=1` held.
  - Required: enables 0 and flushes 1 for 3 cycles, `o_stall_cnt=3`, then one redirect cycle and `o_flush_cnt=1`.
- **Forwarding priority:**
  - Stimulus: `rs1_addr_ex=x7`, with MEM and WB both writing x7.
  - Required: `o_fwd_a_sel=01`.
  - Stimulus: `rs1_addr_ex=x0`, with MEM writing x0.
  - Required: `00`.
- **Watchdog:**
  - With `TIMEOUT=4`: 3 busy cycles leave `o_mem_timeout=0`; 4 busy cycles set it to 1, and it stays 1 after busy drops.
  - Async reset then clears it along with all counters, with no clock edge needed.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline control constants: writeback selects, forwarding selects
// and the hazard unit's FSM state type.
package pipe_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    // A producing stage matches a consumer only if it writes a non-x0 register.
    function automatic logic reg_match(input logic wren, input logic [4:0] rd,
                                       input logic [4:0] rs);
        return wren && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand EX forwarding comparator; the MEM stage has priority over WB.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [4:0] rs_addr_ex,
    input  logic [4:0] rd_addr_mem,
    input  logic       rd_wren_mem,
    input  logic [4:0] rd_addr_wb,
    input  logic       rd_wren_wb,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_match(rd_wren_mem, rd_addr_mem, rs_addr_ex)) begin
            sel = FWD_MEM;
        end else if (reg_match(rd_wren_wb, rd_addr_wb, rs_addr_ex)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard / flow-control unit: stage enables, flushes, forwarding,
// LSU freeze with watchdog, and stall/flush event counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       rs1_addr_id,
    input  logic [4:0]       rs2_addr_id,
    input  logic [4:0]       rs1_addr_ex,
    input  logic [4:0]       rs2_addr_ex,
    input  logic [4:0]       rd_addr_ex,
    input  logic             rd_wren_ex,
    input  logic [1:0]       wb_sel_ex,
    input  logic [4:0]       rd_addr_mem,
    input  logic             rd_wren_mem,
    input  logic [4:0]       rd_addr_wb,
    input  logic             rd_wren_wb,
    input  logic             pc_sel_ex,
    input  logic             i_lsu_busy,
    output logic             o_pc_en,
    output logic             o_enable_if,
    output logic             o_enable_id,
    output logic             o_flush_if_n,
    output logic             o_flush_id_n,
    output logic [1:0]       o_fwd_a_sel,
    output logic [1:0]       o_fwd_b_sel,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int unsigned      WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    hz_state_e         state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_base;
    logic [WAIT_W-1:0] wait_nxt;
    logic              freeze;
    logic              redirect;
    logic              load_use;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

    fwd_sel u_fwd_a (
        .rs_addr_ex  (rs1_addr_ex),
        .rd_addr_mem (rd_addr_mem),
        .rd_wren_mem (rd_wren_mem),
        .rd_addr_wb  (rd_addr_wb),
        .rd_wren_wb  (rd_wren_wb),
        .sel         (fwd_a)
    );

    fwd_sel u_fwd_b (
        .rs_addr_ex  (rs2_addr_ex),
        .rd_addr_mem (rd_addr_mem),
        .rd_wren_mem (rd_wren_mem),
        .rd_addr_wb  (rd_addr_wb),
        .rd_wren_wb  (rd_wren_wb),
        .sel         (fwd_b)
    );

    always_comb begin
        freeze   = i_lsu_busy;
        redirect = pc_sel_ex && !i_lsu_busy;
        load_use = !i_lsu_busy && !pc_sel_ex && (wb_sel_ex == WB_MEM) &&
                   (reg_match(rd_wren_ex, rd_addr_ex, rs1_addr_id) ||
                    reg_match(rd_wren_ex, rd_addr_ex, rs2_addr_id));
    end

    always_comb begin
        o_pc_en      = 1'b1;
        o_enable_if  = 1'b1;
        o_enable_id  = 1'b1;
        o_flush_if_n = 1'b1;
        o_flush_id_n = 1'b1;
        if (!i_reset) begin
            o_pc_en      = 1'b0;
            o_enable_if  = 1'b0;
            o_enable_id  = 1'b0;
            o_flush_if_n = 1'b0;
            o_flush_id_n = 1'b0;
        end else if (freeze) begin
            o_pc_en     = 1'b0;
            o_enable_if = 1'b0;
            o_enable_id = 1'b0;
        end else if (redirect) begin
            o_flush_if_n = 1'b0;
            o_flush_id_n = 1'b0;
        end else if (load_use) begin
            o_pc_en      = 1'b0;
            o_enable_if  = 1'b0;
            o_flush_id_n = 1'b0;
        end
        o_fwd_a_sel = i_reset ? fwd_a : FWD_RF;
        o_fwd_b_sel = i_reset ? fwd_b : FWD_RF;
    end

    // wait_nxt counts busy cycles including the RUN->MEM_WAIT one, so a freeze
    // of exactly TIMEOUT cycles reaches WAIT_MAX on its last busy edge.
    always_comb begin
        wait_base = (state == MEM_WAIT) ? wait_cnt : '0;
        wait_nxt  = '0;
        if (i_lsu_busy) begin
            wait_nxt = (wait_base == WAIT_MAX) ? WAIT_MAX : wait_base + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= RUN;
            wait_cnt      <= '0;
            o_mem_timeout <= 1'b0;
            o_stall_cnt   <= '0;
            o_flush_cnt   <= '0;
        end else begin
            state    <= i_lsu_busy ? MEM_WAIT : RUN;
            wait_cnt <= wait_nxt;
            if (i_lsu_busy && (wait_nxt == WAIT_MAX)) begin
                o_mem_timeout <= 1'b1;
            end
            if (freeze || load_use) begin
                o_stall_cnt <= o_stall_cnt + 1'b1;
            end
            if (redirect) begin
                o_flush_cnt <= o_flush_cnt + 1'b1;
            end
        end
    end

endmodule
